// File: rtl/pht_update_queue_if.sv
// rtl/pht_update_queue_if.sv - update, array-write and lookup signals of the PHT write-side queue
interface pht_update_queue_if #(
  parameter int INDEX_BITS = 5,
  parameter int CTR_WIDTH  = 2,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  upd_valid;
  logic                  upd_ready;
  logic [INDEX_BITS-1:0] upd_index;
  logic                  upd_taken;
  logic [CTR_WIDTH-1:0]  upd_ctr;
  logic                  arr_busy;
  logic                  arr_write;
  logic [INDEX_BITS-1:0] arr_write_index;
  logic [CTR_WIDTH-1:0]  arr_datain;
  logic [INDEX_BITS-1:0] lookup_index;
  logic                  lookup_hit;
  logic [CTR_WIDTH-1:0]  lookup_ctr;
  logic [CW-1:0]         count;

  modport master (
    output upd_valid, upd_index, upd_taken, upd_ctr, arr_busy, lookup_index,
    input  upd_ready, arr_write, arr_write_index, arr_datain, lookup_hit, lookup_ctr, count
  );

  modport slave (
    input  upd_valid, upd_index, upd_taken, upd_ctr, arr_busy, lookup_index,
    output upd_ready, arr_write, arr_write_index, arr_datain, lookup_hit, lookup_ctr, count
  );
endinterface

// File: rtl/pht_update_queue.sv
// rtl/pht_update_queue.sv - merging write queue for the 2-bit PHT with lookup forwarding
module pht_update_queue #(
  parameter int INDEX_BITS = 5,
  parameter int CTR_WIDTH  = 2,
  parameter int DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  pht_update_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};

  logic [DEPTH-1:0]      val_q;
  logic [INDEX_BITS-1:0] idx_q [DEPTH];
  logic [CTR_WIDTH-1:0]  ctr_q [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  match_any;
  logic [PW-1:0]         match_ptr;
  logic                  fwd_hit;
  logic [CTR_WIDTH-1:0]  fwd_ctr;
  logic [CTR_WIDTH-1:0]  base, new_ctr;
  logic                  accept, pop, merge, alloc;

  always_comb begin
    match_any = 1'b0;
    match_ptr = '0;
    fwd_hit   = 1'b0;
    fwd_ctr   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (val_q[i] && idx_q[i] == bus.upd_index) begin
        match_any = 1'b1;
        match_ptr = PW'(i);
      end
      if (val_q[i] && idx_q[i] == bus.lookup_index) begin
        fwd_hit = 1'b1;
        fwd_ctr = ctr_q[i];
      end
    end
  end

  // Gating with reset_n keeps ready low while reset is held, yet high right after release.
  assign bus.upd_ready       = reset_n && (count_q < CW'(DEPTH));
  assign bus.arr_write       = (count_q != '0) && !bus.arr_busy;
  assign bus.arr_write_index = idx_q[head_q];
  assign bus.arr_datain      = ctr_q[head_q];
  assign bus.lookup_hit      = fwd_hit;
  assign bus.lookup_ctr      = fwd_ctr;
  assign bus.count           = count_q;

  assign accept = bus.upd_valid && bus.upd_ready;
  assign pop    = bus.arr_write;
  assign base   = match_any ? ctr_q[match_ptr] : bus.upd_ctr;

  always_comb begin
    new_ctr = base;
    if (bus.upd_taken) begin
      if (base != CTR_MAX) new_ctr = base + CTR_WIDTH'(1);
    end else begin
      if (base != '0) new_ctr = base - CTR_WIDTH'(1);
    end
  end

  // A match on the head that leaves this cycle cannot be updated in place; it re-allocates.
  assign merge   = accept && match_any && !(pop && match_ptr == head_q);
  assign alloc   = accept && !merge;
  assign head_d  = pop   ? head_q + PW'(1) : head_q;
  assign tail_d  = alloc ? tail_q + PW'(1) : tail_q;
  assign count_d = count_q + CW'(alloc) - CW'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      if (pop) val_q[head_q] <= 1'b0;
      if (merge) ctr_q[match_ptr] <= new_ctr;
      if (alloc) begin
        val_q[tail_q] <= 1'b1;
        idx_q[tail_q] <= bus.upd_index;
        ctr_q[tail_q] <= new_ctr;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_pht_update_queue.sv
// tb/tb_pht_update_queue.sv - vector table plus write scoreboard for pht_update_queue
module tb_pht_update_queue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pht_update_queue_if #(.INDEX_BITS(5), .CTR_WIDTH(2), .DEPTH(4)) bus ();

  pht_update_queue #(.INDEX_BITS(5), .CTR_WIDTH(2), .DEPTH(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic       v;
    logic [4:0] idx;
    logic       tk;
    logic [1:0] ctr;
    logic       busy;
    logic [4:0] lk;
    logic       e_rdy;
    logic [2:0] e_cnt;
    logic       e_hit;
    logic [1:0] e_lc;
    logic       push;
    logic [4:0] w_idx;
    logic [1:0] w_dat;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic vec_t mk(logic v, logic [4:0] idx, logic tk, logic [1:0] ctr, logic busy,
                              logic [4:0] lk, logic e_rdy, logic [2:0] e_cnt, logic e_hit,
                              logic [1:0] e_lc, logic push, logic [4:0] w_idx, logic [1:0] w_dat);
    vec_t r;
    r.v = v; r.idx = idx; r.tk = tk; r.ctr = ctr; r.busy = busy; r.lk = lk;
    r.e_rdy = e_rdy; r.e_cnt = e_cnt; r.e_hit = e_hit; r.e_lc = e_lc;
    r.push = push; r.w_idx = w_idx; r.w_dat = w_dat;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic rdy, input logic [2:0] cnt, input logic hit, input logic [1:0] lc);
    check("upd_ready", 32'(bus.upd_ready), 32'(rdy));
    check("count", 32'(bus.count), 32'(cnt));
    check("lookup_hit", 32'(bus.lookup_hit), 32'(hit));
    check("lookup_ctr", 32'(bus.lookup_ctr), 32'(lc));
  endtask

  task automatic drive(input logic v, input logic [4:0] idx, input logic tk, input logic [1:0] ctr,
                       input logic busy, input logic [4:0] lk);
    bus.upd_valid = v; bus.upd_index = idx; bus.upd_taken = tk; bus.upd_ctr = ctr;
    bus.arr_busy = busy; bus.lookup_index = lk;
  endtask

  // Every array write seen must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (reset_n && bus.arr_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {25'd0, bus.arr_write_index, bus.arr_datain}, 32'h7f);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        check("write_index", 32'(bus.arr_write_index), 32'(e[6:2]));
        check("write_data", 32'(bus.arr_datain), 32'(e[1:0]));
      end
    end
  end

  initial begin
    //       v idx tk ctr bsy lk   rdy cnt hit lc  push widx wdat
    vecs.push_back(mk(1, 5, 1, 1, 0, 5,   1, 0, 0, 0,  1, 5, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5,   1, 1, 1, 2,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5,   1, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 3, 1, 1, 1, 3,   1, 0, 0, 0,  1, 3, 3));
    vecs.push_back(mk(1, 3, 1, 1, 1, 3,   1, 1, 1, 2,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3,   1, 1, 1, 3,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3,   1, 1, 1, 3,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 3,   1, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 9, 1, 3, 0, 9,   1, 0, 0, 0,  1, 9, 3));
    vecs.push_back(mk(1, 10, 0, 0, 0, 10, 1, 1, 0, 0,  1, 10, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10,  1, 1, 1, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10,  1, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 0,   1, 0, 0, 0,  1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0,   1, 1, 1, 1,  1, 1, 2));
    vecs.push_back(mk(1, 2, 0, 2, 1, 0,   1, 2, 1, 1,  1, 2, 1));
    vecs.push_back(mk(1, 3, 0, 3, 1, 3,   1, 3, 0, 0,  1, 3, 2));
    vecs.push_back(mk(1, 4, 1, 2, 1, 2,   0, 4, 1, 1,  1, 4, 3));
    vecs.push_back(mk(1, 4, 1, 2, 1, 3,   0, 4, 1, 2,  0, 0, 0));
    vecs.push_back(mk(1, 4, 1, 2, 0, 0,   0, 4, 1, 1,  0, 0, 0));
    vecs.push_back(mk(1, 4, 1, 2, 0, 4,   1, 3, 0, 0,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4,   1, 3, 1, 3,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4,   1, 2, 1, 3,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4,   1, 1, 1, 3,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4,   1, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 1, 1, 7,   1, 0, 0, 0,  1, 7, 2));
    vecs.push_back(mk(1, 7, 1, 0, 0, 7,   1, 1, 1, 2,  1, 7, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 7,   1, 1, 1, 3,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 7,   1, 0, 0, 0,  0, 0, 0));

    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_outputs(0, 0, 0, 0);
    check("reset_arr_write", 32'(bus.arr_write), 0);
    check("reset_write_index", 32'(bus.arr_write_index), 0);
    check("reset_datain", 32'(bus.arr_datain), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      drive(vecs[k].v, vecs[k].idx, vecs[k].tk, vecs[k].ctr, vecs[k].busy, vecs[k].lk);
      if (vecs[k].push) exp_q.push_back({vecs[k].w_idx, vecs[k].w_dat});
      @(negedge clk);
      check_outputs(vecs[k].e_rdy, vecs[k].e_cnt, vecs[k].e_hit, vecs[k].e_lc);
    end

    // Reset with three pending entries: nothing of them may ever reach the array.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 drive(1, 5'(11 + i), 1, 1, 1, 11);
    end
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 1, 11);
    @(negedge clk);
    check_outputs(1, 3, 1, 2);
    @(posedge clk);
    #1;
    bus.arr_busy = 1'b0;
    reset_n = 1'b0;
    #1;
    check_outputs(0, 0, 0, 0);
    check("midreset_arr_write", 32'(bus.arr_write), 0);
    check("midreset_write_index", 32'(bus.arr_write_index), 0);
    check("midreset_datain", 32'(bus.arr_datain), 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_outputs(1, 0, 0, 0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
